// File: rtl/timer_int_arbiter.sv
// Multi-channel timer interrupt scheduler: per-channel pending bits,
// round-robin or fixed-priority arbitration among enabled pending channels,
// and a single vectored request held until acknowledged or retracted.

// Per-channel pending/status bit.
module timer_int_ch (
  input  logic clk,
  input  logic rst_n,
  input  logic compare,
  input  logic clr,
  input  logic ack_hit,
  output logic st
);

  // Clear beats a new compare; a new compare beats the ack that would drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       st <= 1'b0;
    else if (clr)     st <= 1'b0;
    else if (compare) st <= 1'b1;
    else if (ack_hit) st <= 1'b0;
  end

endmodule

module timer_int_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] compare,
  input  logic [NUM_CH-1:0] int_en,
  input  logic [NUM_CH-1:0] int_clr,
  input  logic              irq_ack,
  output logic [NUM_CH-1:0] int_st,
  output logic              irq,
  output logic [ID_W-1:0]   irq_id
);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   irq_id_nxt;
  logic              irq_nxt;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] ack_vec;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   id_inc;
  logic              ack_take;
  logic              cur_elig;
  logic              found;
  int                idx;

  assign elig     = int_st & int_en;
  assign ack_take = (state == S_ASSERT) && irq_ack;
  assign ack_vec  = ack_take ? (NUM_CH'(1) << irq_id) : '0;
  assign cur_elig = elig[irq_id];
  assign id_inc   = (irq_id == ID_W'(NUM_CH - 1)) ? '0 : irq_id + ID_W'(1);

  // Per-channel status bits.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_int_ch u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .compare (compare[g]),
      .clr     (int_clr[g]),
      .ack_hit (ack_vec[g]),
      .st      (int_st[g])
    );
  end

  // Winner: first eligible channel scanning up from the search base, wrapping.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ((RR != 0) ? int'(rr_ptr) : 0) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an ack outranks a same-cycle retract.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (|elig) state_nxt = S_ASSERT;
      S_ASSERT: begin
        if (irq_ack)        state_nxt = S_GAP;
        else if (!cur_elig) state_nxt = S_IDLE;
      end
      S_GAP:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the round-robin pointer.
  always_comb begin
    irq_nxt    = irq;
    irq_id_nxt = irq_id;
    rr_ptr_nxt = rr_ptr;
    case (state)
      S_IDLE: begin
        if (|elig) begin
          irq_nxt    = 1'b1;
          irq_id_nxt = win;
        end else begin
          irq_nxt    = 1'b0;
        end
      end
      S_ASSERT: begin
        if (irq_ack) begin
          irq_nxt = 1'b0;
          if (RR != 0) rr_ptr_nxt = id_inc;
        end else if (!cur_elig) begin
          irq_nxt = 1'b0;
        end
      end
      S_GAP:   irq_nxt = 1'b0;
      default: irq_nxt = 1'b0;
    endcase
  end

  // Output and pointer registers; irq_id is frozen while the request is up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq    <= 1'b0;
      irq_id <= '0;
      rr_ptr <= '0;
    end else begin
      irq    <= irq_nxt;
      irq_id <= irq_id_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_timer_int_arbiter.sv
// Random and directed stimulus for a round-robin and a fixed-priority
// instance, both checked every cycle against a cycle-level reference model.
module tb_timer_int_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] compare, int_en, int_clr;
  logic         irq_ack;
  logic [N-1:0] st_rr, st_fp;
  logic         irq_rr, irq_fp;
  logic [1:0]   id_rr, id_fp;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  timer_int_arbiter #(.NUM_CH(N), .ID_W(2), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .compare(compare), .int_en(int_en),
    .int_clr(int_clr), .irq_ack(irq_ack),
    .int_st(st_rr), .irq(irq_rr), .irq_id(id_rr)
  );

  timer_int_arbiter #(.NUM_CH(N), .ID_W(2), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .compare(compare), .int_en(int_en),
    .int_clr(int_clr), .irq_ack(irq_ack),
    .int_st(st_fp), .irq(irq_fp), .irq_id(id_fp)
  );

  // Reference model: pending set, presented channel, phase 0=idle 1=presenting 2=gap.
  typedef struct {
    logic [N-1:0] st;
    bit           irq;
    int           id;
    int           ptr;
    int           ph;
  } mst_t;

  mst_t m [2];  // [0] fixed priority, [1] round robin

  function automatic mst_t mreset();
    mst_t s;
    s.st = '0; s.irq = 0; s.id = 0; s.ptr = 0; s.ph = 0;
    return s;
  endfunction

  function automatic mst_t mstep(input mst_t s, input logic [N-1:0] c, input logic [N-1:0] e,
                                 input logic [N-1:0] k, input logic a, input bit rr);
    mst_t n = s;
    logic [N-1:0] el = s.st & e;
    for (int i = 0; i < N; i++) begin
      if (k[i])                            n.st[i] = 1'b0;
      else if (c[i])                       n.st[i] = 1'b1;
      else if (s.ph == 1 && a && s.id == i) n.st[i] = 1'b0;
    end
    if (s.ph == 0) begin
      if (el != 0) begin
        int base = rr ? s.ptr : 0;
        for (int j = N - 1; j >= 0; j--)
          if (el[(base + j) % N]) n.id = (base + j) % N;
        n.irq = 1; n.ph = 1;
      end
    end else if (s.ph == 1) begin
      if (a) begin
        n.irq = 0; n.ph = 2;
        if (rr) n.ptr = (s.id + 1) % N;
      end else if (!el[s.id]) begin
        n.irq = 0; n.ph = 0;
      end
    end else begin
      n.ph = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rbits(input int pct);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < pct);
    return v;
  endfunction

  // Called just after a falling edge: check, drive, advance the model one edge.
  task automatic step(input logic [N-1:0] c, input logic [N-1:0] e,
                      input logic [N-1:0] k, input logic a);
    chk("st_fp",  32'(st_fp),  32'(m[0].st));
    chk("irq_fp", 32'(irq_fp), 32'(m[0].irq));
    chk("id_fp",  32'(id_fp),  32'(m[0].id));
    chk("st_rr",  32'(st_rr),  32'(m[1].st));
    chk("irq_rr", 32'(irq_rr), 32'(m[1].irq));
    chk("id_rr",  32'(id_rr),  32'(m[1].id));
    compare = c; int_en = e; int_clr = k; irq_ack = a;
    m[0] = mstep(m[0], c, e, k, a, 1'b0);
    m[1] = mstep(m[1], c, e, k, a, 1'b1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  exp_id;
    bit  prev;
    bit  hit;
    int  pc, pk, pe, pa;

    rst_n = 1'b0; compare = '0; int_en = '0; int_clr = '0; irq_ack = 1'b0;
    m[0] = mreset(); m[1] = mreset();
    #1;
    chk("rst_irq_rr", 32'(irq_rr), 0);
    chk("rst_st_rr",  32'(st_rr),  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin fairness: all channels pending forever, every grant acked at once.
    exp_id = 0; prev = 0;
    for (int i = 0; i < 40; i++) begin
      step('1, '1, '0, m[1].irq);
      if (m[1].irq && !prev) begin
        chk("rr_seq", 32'(id_rr), 32'(exp_id));
        exp_id = (exp_id + 1) % N;
      end
      prev = m[1].irq;
    end

    // Drain, then a single compare on ch2 acked a few cycles after presentation.
    step('0, '1, '1, 1'b0);
    for (int i = 0; i < 3; i++) step('0, '1, '0, m[1].irq);
    step(4'b0100, '1, '0, 1'b0);
    for (int i = 0; i < 6; i++) step('0, '1, '0, (i == 4));
    chk("t1_st2", 32'(st_rr[2]), 0);

    // Masked channel: status sets but no request until enabled.
    step(4'b1000, 4'b0111, '0, 1'b0);
    for (int i = 0; i < 3; i++) step('0, 4'b0111, '0, 1'b0);
    chk("mask_irq", 32'(irq_rr), 0);
    chk("mask_st3", 32'(st_rr[3]), 1);
    for (int i = 0; i < 3; i++) step('0, '1, '0, 1'b0);
    chk("unmask_id", 32'(id_rr), 3);
    step('0, '1, '0, 1'b1);

    // Random segments with different compare/clear/enable/ack densities.
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 4)
        0: begin pc = 30; pk = 5;  pe = 90; pa = 50; end
        1: begin pc = 60; pk = 20; pe = 70; pa = 20; end
        2: begin pc = 10; pk = 2;  pe = 50; pa = 80; end
        default: begin pc = 50; pk = 30; pe = 95; pa = 35; end
      endcase
      for (int i = 0; i < 400; i++)
        step(rbits(pc), rbits(pe), rbits(pk), ($urandom_range(0, 99) < pa));

      // Reset while a request is presented: outputs drop without a clock edge.
      if (seg == 3 || seg == 7) begin
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
          if (m[1].irq) hit = 1;
          else step('1, '1, '0, 1'b0);
        end
        chk("rst_found_assert", 32'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_irq_rr", 32'(irq_rr), 0);
        chk("arst_st_rr",  32'(st_rr),  0);
        chk("arst_irq_fp", 32'(irq_fp), 0);
        chk("arst_st_fp",  32'(st_fp),  0);
        chk("arst_id_rr",  32'(id_rr),  0);
        compare = '0; int_clr = '0; irq_ack = 1'b0;
        m[0] = mreset(); m[1] = mreset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
